dds_multichannel: RTL and testbench

Parametrised, time-multiplexed direct-digital-synthesis tone generator for the DAC/PWM output path. It produces one sample per channel on every sample tick, from a per-channel phase accumulator, and supports four waveform modes: sine from an external ROM, square, sawtooth and triangle. It replaces the single-channel tick / address-counter pair in the top level. It drives the shared sine ROM and hands each sample, tagged with its channel number, to the downstream SPI DAC and PWM blocks.

---
 rtl/dds_multichannel.sv | 160 ++++++++++++++++
 tb/tb_dds_multichannel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multichannel.sv
// Time-multiplexed DDS tone generator: one phase accumulator per channel,
// swept once per sample tick through a shared synchronous sine ROM.
//
// state  | meaning
// S_IDLE | waiting for a tick with enable high
// S_ADDR | form rom_addr from the channel phase, advance the phase
// S_WAIT | ROM access cycle
// S_OUT  | form the sample from the used phase and rom_data
module dds_multichannel #(
  parameter int N_CH     = 2,
  parameter int PHASE_W  = 16,
  parameter int ADR_W    = 10,
  parameter int DATA_W   = 10,
  parameter int TICK_DIV = 5000
) (
  input  logic                                     CLOCK_50,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic [N_CH*PHASE_W-1:0]                  step_in,
  input  logic [N_CH*2-1:0]                        mode_in,
  input  logic [N_CH-1:0]                          phase_clr,
  output logic [ADR_W-1:0]                         rom_addr,
  input  logic [DATA_W-1:0]                        rom_data,
  output logic                                     tick,
  output logic [DATA_W-1:0]                        sample_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] sample_ch,
  output logic                                     sample_valid,
  output logic                                     overrun
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0] LAST_T  = TCNT_W'(TICK_DIV - 1);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic                 tick_q, tick_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [N_CH-1:0]      clr_q, clr_d;
  logic [PHASE_W-1:0]   step_sh_q [N_CH];
  logic [PHASE_W-1:0]   step_sh_d [N_CH];
  logic [1:0]           mode_sh_q [N_CH];
  logic [1:0]           mode_sh_d [N_CH];
  logic [PHASE_W-1:0]   phase_q   [N_CH];
  logic [PHASE_W-1:0]   phase_d   [N_CH];
  // only the top DATA_W+1 bits of the used phase feed the waveform math
  logic [DATA_W:0]      p_q, p_d;
  logic [ADR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]    sample_data_q, sample_data_d;
  logic [CH_W-1:0]      sample_ch_q, sample_ch_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 overrun_q, overrun_d;

  logic [PHASE_W-1:0]   p_used;
  logic [DATA_W-1:0]    wave;

  always_comb begin
    tcnt_d         = (tcnt_q == LAST_T) ? '0 : tcnt_q + 1'b1;
    tick_d         = (tcnt_d == LAST_T);
    state_d        = state_q;
    ch_d           = ch_q;
    clr_d          = clr_q;
    step_sh_d      = step_sh_q;
    mode_sh_d      = mode_sh_q;
    phase_d        = phase_q;
    p_d            = p_q;
    rom_addr_d     = rom_addr_q;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    p_used         = clr_q[ch_q] ? '0 : phase_q[ch_q];

    case (mode_sh_q[ch_q])
      2'b00:   wave = rom_data;
      2'b01:   wave = p_q[DATA_W] ? '0 : '1;
      2'b10:   wave = p_q[DATA_W:1];
      default: wave = p_q[DATA_W] ? ~p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    endcase

    case (state_q)
      S_IDLE: begin
        if (tick_q && enable) begin
          state_d = S_ADDR;
          ch_d    = '0;
          clr_d   = phase_clr;
          for (int c = 0; c < N_CH; c++) begin
            step_sh_d[c] = step_in[c*PHASE_W +: PHASE_W];
            mode_sh_d[c] = mode_in[2*c +: 2];
          end
        end
      end
      S_ADDR: begin
        p_d           = p_used[PHASE_W-1 -: DATA_W+1];
        rom_addr_d    = p_used[PHASE_W-1 -: ADR_W];
        phase_d[ch_q] = clr_q[ch_q] ? '0 : phase_q[ch_q] + step_sh_q[ch_q];
        state_d       = S_WAIT;
      end
      S_WAIT: state_d = S_OUT;
      default: begin
        sample_data_d  = wave;
        sample_ch_d    = ch_q;
        sample_valid_d = 1'b1;
        if (ch_q == LAST_CH) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_ADDR;
        end
      end
    endcase

    // registered so it lands in the same cycle as the dropped tick
    overrun_d = tick_d && (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tcnt_q         <= '0;
      tick_q         <= 1'b0;
      ch_q           <= '0;
      clr_q          <= '0;
      step_sh_q      <= '{default: '0};
      mode_sh_q      <= '{default: '0};
      phase_q        <= '{default: '0};
      p_q            <= '0;
      rom_addr_q     <= '0;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tcnt_q         <= tcnt_d;
      tick_q         <= tick_d;
      ch_q           <= ch_d;
      clr_q          <= clr_d;
      step_sh_q      <= step_sh_d;
      mode_sh_q      <= mode_sh_d;
      phase_q        <= phase_d;
      p_q            <= p_d;
      rom_addr_q     <= rom_addr_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign tick         = tick_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_multichannel.sv
// Directed bench for dds_multichannel: three instances (1 channel, 2 channels
// slow tick, 2 channels fast tick) each with an echo ROM (data = address).
module tb_dds_multichannel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // instance A: one channel, TICK_DIV=8
  logic        rst_a, en_a, tick_a, sv_a, ov_a;
  logic [15:0] step_a;
  logic [1:0]  mode_a;
  logic [0:0]  clr_a, sch_a;
  logic [9:0]  addr_a, rd_a, sd_a;
  always @(posedge clk) rd_a <= addr_a;

  dds_multichannel #(.N_CH(1), .PHASE_W(16), .ADR_W(10), .DATA_W(10), .TICK_DIV(8)) dut_a (
    .CLOCK_50(clk), .reset(rst_a), .enable(en_a), .step_in(step_a), .mode_in(mode_a),
    .phase_clr(clr_a), .rom_addr(addr_a), .rom_data(rd_a), .tick(tick_a),
    .sample_data(sd_a), .sample_ch(sch_a), .sample_valid(sv_a), .overrun(ov_a));

  // instance B: two channels, TICK_DIV=20
  logic        rst_b, en_b, tick_b, sv_b, ov_b;
  logic [31:0] step_b;
  logic [3:0]  mode_b;
  logic [1:0]  clr_b;
  logic [0:0]  sch_b;
  logic [9:0]  addr_b, rd_b, sd_b;
  logic        ov_b_seen = 1'b0;
  always @(posedge clk) rd_b <= addr_b;
  always @(negedge clk) if (ov_b === 1'b1) ov_b_seen = 1'b1;

  dds_multichannel #(.N_CH(2), .PHASE_W(16), .ADR_W(10), .DATA_W(10), .TICK_DIV(20)) dut_b (
    .CLOCK_50(clk), .reset(rst_b), .enable(en_b), .step_in(step_b), .mode_in(mode_b),
    .phase_clr(clr_b), .rom_addr(addr_b), .rom_data(rd_b), .tick(tick_b),
    .sample_data(sd_b), .sample_ch(sch_b), .sample_valid(sv_b), .overrun(ov_b));

  // instance C: two channels, TICK_DIV=5 (too short for a full sweep)
  logic        rst_c, en_c, tick_c, sv_c, ov_c;
  logic [31:0] step_c;
  logic [3:0]  mode_c;
  logic [1:0]  clr_c;
  logic [0:0]  sch_c;
  logic [9:0]  addr_c, rd_c, sd_c;
  always @(posedge clk) rd_c <= addr_c;

  dds_multichannel #(.N_CH(2), .PHASE_W(16), .ADR_W(10), .DATA_W(10), .TICK_DIV(5)) dut_c (
    .CLOCK_50(clk), .reset(rst_c), .enable(en_c), .step_in(step_c), .mode_in(mode_c),
    .phase_clr(clr_c), .rom_addr(addr_c), .rom_data(rd_c), .tick(tick_c),
    .sample_data(sd_c), .sample_ch(sch_c), .sample_valid(sv_c), .overrun(ov_c));

  task automatic get_a(input string tag, output logic [9:0] d);
    bit got = 1'b0;
    d = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sv_a === 1'b1) begin
        got = 1'b1;
        d   = sd_a;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s timeout observed=no_sample expected=sample_valid", tag);
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic wait_tick_b(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (tick_b === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s timeout observed=no_tick expected=tick", tag);
    end
  endtask

  logic [9:0] d;
  int tn, ch1cnt, tk, n;
  bit seen;
  logic [9:0] tri_exp [8];

  initial begin
    tri_exp = '{10'd0, 10'd256, 10'd512, 10'd768, 10'd1023, 10'd767, 10'd511, 10'd255};
    rst_a = 1'b1; en_a = 1'b0; step_a = '0; mode_a = '0; clr_a = '0;
    rst_b = 1'b1; en_b = 1'b0; step_b = '0; mode_b = '0; clr_b = '0;
    rst_c = 1'b1; en_c = 1'b0; step_c = '0; mode_c = '0; clr_c = '0;
    repeat (3) @(negedge clk);

    chk("rst_rom_addr", addr_a, 0);
    chk("rst_sample_data", sd_a, 0);
    chk("rst_sample_ch", sch_a, 0);
    chk("rst_sample_valid", sv_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_overrun", ov_a, 0);

    // overrun: every other tick dropped, channel 1 (saw, step 0x200) still produced
    step_c = {16'h0200, 16'h0100};
    mode_c = {2'b10, 2'b10};
    en_c   = 1'b1;
    rst_c  = 1'b0;
    tn = 0;
    ch1cnt = 0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      chk("c_tick", tick_c, (c % 5 == 4));
      if (tick_c === 1'b1) begin
        chk("c_overrun_tick", ov_c, tn % 2);
        tn++;
      end else begin
        chk("c_overrun_quiet", ov_c, 0);
      end
      if (sv_c === 1'b1 && sch_c === 1'b1) begin
        chk("c_ch1_data", sd_c, ch1cnt * 8);
        ch1cnt++;
      end
    end
    chk("c_ch1_count", ch1cnt, 3);
    rst_c = 1'b1;

    // two channels: sine step 0x0400 / saw step 0x0800, check latency and data
    step_b = {16'h0800, 16'h0400};
    mode_b = {2'b10, 2'b00};
    en_b   = 1'b1;
    rst_b  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      wait_tick_b("b_tick");
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        chk("b_valid_timing", sv_b, (k == 4 || k == 7));
        if (k == 4) begin
          chk("b_ch0_tag", sch_b, 0);
          chk("b_ch0_sine", sd_b, s * 16);
        end
        if (k == 7) begin
          chk("b_ch1_tag", sch_b, 1);
          chk("b_ch1_saw", sd_b, s * 32);
        end
      end
    end

    // reset in the middle of the third sweep
    wait_tick_b("b_tick3");
    repeat (4) @(negedge clk);
    chk("b_pre_reset_valid", sv_b, 1);
    rst_b = 1'b1;
    #1;
    chk("b_reset_rom_addr", addr_b, 0);
    chk("b_reset_sample_data", sd_b, 0);
    chk("b_reset_sample_ch", sch_b, 0);
    chk("b_reset_sample_valid", sv_b, 0);
    chk("b_reset_tick", tick_b, 0);
    chk("b_reset_overrun", ov_b, 0);
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (tick_b === 1'b1) n = i;
    end
    chk("b_first_tick_edges", n, 19);
    repeat (4) @(negedge clk);
    chk("b_post_reset_ch0_valid", sv_b, 1);
    chk("b_post_reset_ch0_data", sd_b, 0);
    repeat (3) @(negedge clk);
    chk("b_post_reset_ch1_valid", sv_b, 1);
    chk("b_post_reset_ch1_data", sd_b, 0);
    chk("b_no_overrun", ov_b_seen, 0);

    // sine through the echo ROM, step 64: address advances by one per sample
    step_a = 16'd64;
    mode_a = 2'b00;
    en_a   = 1'b1;
    reset_a();
    for (int k = 0; k <= 1024; k++) begin
      get_a("a_sine_wait", d);
      if (k < 4 || k >= 1023) chk("a_sine", d, k % 1024);
    end

    step_a = 16'h2000;
    mode_a = 2'b10;
    reset_a();
    for (int k = 0; k <= 8; k++) begin
      get_a("a_saw_wait", d);
      chk("a_saw", d, (k * 128) % 1024);
    end

    mode_a = 2'b01;
    reset_a();
    for (int k = 0; k < 8; k++) begin
      get_a("a_square_wait", d);
      chk("a_square", d, (k < 4) ? 1023 : 0);
    end

    mode_a = 2'b11;
    reset_a();
    for (int k = 0; k < 8; k++) begin
      get_a("a_tri_wait", d);
      chk("a_triangle", d, tri_exp[k]);
    end

    // enable low across three ticks, then a one-tick phase clear
    mode_a = 2'b10;
    reset_a();
    get_a("a_en_wait0", d);
    chk("a_en_s0", d, 0);
    get_a("a_en_wait1", d);
    chk("a_en_s1", d, 128);
    en_a = 1'b0;
    tk = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && tk < 3; i++) begin
      @(negedge clk);
      if (tick_a === 1'b1) tk++;
      if (sv_a !== 1'b0) seen = 1'b1;
    end
    chk("a_disabled_ticks", tk, 3);
    chk("a_disabled_no_valid", seen, 0);
    en_a = 1'b1;
    get_a("a_en_wait2", d);
    chk("a_phase_held", d, 256);
    clr_a = 1'b1;
    get_a("a_clr_wait", d);
    chk("a_clr_sample", d, 0);
    clr_a = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
